// File: rtl/booth4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth4_pkg
// Description : Shared definitions for the radix-4 Booth multiplier slice:
//               controller state encoding, recode constants and the default
//               operand width used by the controller and datapath registers.
// Revision    : 1.0 - initial release
// ============================================================================
package booth4_pkg;

  // Operand width shared with reg_A / reg_Q / reg_M.
  localparam int BOOTH_WIDTH = 8;

  // Controller states, binary encoded.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_EVAL  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  // Recode actions, packed as {add_en, sel_2m, sub}.
  localparam logic [2:0] REC_NOP = 3'b000;  // digit  0
  localparam logic [2:0] REC_PM  = 3'b100;  // digit +1 : A + M
  localparam logic [2:0] REC_P2M = 3'b110;  // digit +2 : A + 2M
  localparam logic [2:0] REC_MM  = 3'b101;  // digit -1 : A - M
  localparam logic [2:0] REC_M2M = 3'b111;  // digit -2 : A - 2M

endpackage : booth4_pkg
`default_nettype wire

// File: rtl/booth4_recoder.sv
`default_nettype none
// ============================================================================
// Module      : booth4_recoder
// Description : Combinational radix-4 Booth recoder. Maps the Q-register
//               window {Q[1], Q[0], Q[-1]} to an adder action.
// Ports       : q_bits  in  3  {Q[1], Q[0], Q[-1]}
//               add_en  out 1  write adder result into A
//               sel_2m  out 1  adder operand is 2M (else M)
//               sub     out 1  adder subtracts the operand
// Revision    : 1.0 - initial release
// ============================================================================
module booth4_recoder
  import booth4_pkg::*;
(
  input  logic [2:0] q_bits,
  output logic       add_en,
  output logic       sel_2m,
  output logic       sub
);

  logic [2:0] w_rec;

  always_comb begin
    w_rec = REC_NOP;
    case (q_bits)
      3'b000, 3'b111: w_rec = REC_NOP;
      3'b001, 3'b010: w_rec = REC_PM;
      3'b011:         w_rec = REC_P2M;
      3'b100:         w_rec = REC_M2M;
      3'b101, 3'b110: w_rec = REC_MM;
      default:        w_rec = REC_NOP;
    endcase
  end

  assign {add_en, sel_2m, sub} = w_rec;

endmodule : booth4_recoder
`default_nettype wire

// File: rtl/booth4_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : booth4_ctrl
// Description : Sequencer for the radix-4 Booth multiplier datapath. Runs
//               INIT, then N_ITER pairs of EVAL (recode + add/sub) and SHIFT
//               (arithmetic shift right by 2), then OUT (latch product).
// Ports       : clk     in  1  system clock, rising edge
//               reset   in  1  asynchronous active-high reset
//               start   in  1  begin a multiplication (sampled in IDLE)
//               q_bits  in  3  {Q[1], Q[0], Q[-1]}
//               c0      out 1  clear A and Q[-1]
//               c1      out 1  load M and Q
//               c2      out 1  write adder sum into A
//               c3      out 1  adder operand select (1 = 2M)
//               c4      out 1  adder subtract
//               c5      out 1  shift A:Q:Q[-1] right by 2
//               c6      out 1  latch product into output register
//               busy    out 1  high from INIT through OUT
//               done    out 1  one-cycle pulse with c6
// Revision    : 1.0 - initial release
// ============================================================================
module booth4_ctrl
  import booth4_pkg::*;
#(
  parameter int WIDTH  = BOOTH_WIDTH,            // must be even
  parameter int N_ITER = WIDTH / 2,
  parameter int CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] q_bits,
  output logic       c0,
  output logic       c1,
  output logic       c2,
  output logic       c3,
  output logic       c4,
  output logic       c5,
  output logic       c6,
  output logic       busy,
  output logic       done
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_add_en;
  logic               w_sel_2m;
  logic               w_sub;
  logic               w_last;

  booth4_recoder u_recoder (
    .q_bits (q_bits),
    .add_en (w_add_en),
    .sel_2m (w_sel_2m),
    .sub    (w_sub)
  );

  assign w_last = (r_cnt == CNT_W'(N_ITER - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Every strobe decodes from the state register, so an asynchronous reset
  // clears all outputs in the same cycle. The recoder outputs are only
  // passed through in EVAL; elsewhere the strobes are forced to constant 0
  // so an unknown q_bits cannot leak out.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    c0          = 1'b0;
    c1          = 1'b0;
    c2          = 1'b0;
    c3          = 1'b0;
    c4          = 1'b0;
    c5          = 1'b0;
    c6          = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_INIT;
      end
      ST_INIT: begin
        c0          = 1'b1;
        c1          = 1'b1;
        busy        = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_EVAL;
      end
      ST_EVAL: begin
        busy        = 1'b1;
        c2          = w_add_en;
        c3          = w_sel_2m;
        c4          = w_sub;
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        c5   = 1'b1;
        busy = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_OUT;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          w_state_nxt = ST_EVAL;
        end
      end
      ST_OUT: begin
        c6          = 1'b1;
        done        = 1'b1;
        busy        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule : booth4_ctrl
`default_nettype wire

// File: tb/tb_booth4_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth4_ctrl
// Description : Directed self-checking bench for booth4_ctrl. Output strobes
//               are compared as one vector {c0,c1,c2,c3,c4,c5,c6,busy,done}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth4_ctrl;

  localparam int N = 4;  // iterations for the default 8-bit width

  // Expected output vectors {c0,c1,c2,c3,c4,c5,c6,busy,done}
  localparam logic [8:0] E_IDLE  = 9'b00_000_00_00;
  localparam logic [8:0] E_INIT  = 9'b11_000_00_10;
  localparam logic [8:0] E_NOP   = 9'b00_000_00_10;
  localparam logic [8:0] E_SHIFT = 9'b00_000_10_10;
  localparam logic [8:0] E_OUT   = 9'b00_000_01_11;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] q_bits;
  logic       c0, c1, c2, c3, c4, c5, c6, busy, done;
  logic [8:0] outs;

  int n_checks = 0;
  int n_err    = 0;
  bit mon_en   = 1'b0;
  int done_cnt;

  assign outs = {c0, c1, c2, c3, c4, c5, c6, busy, done};

  booth4_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .q_bits (q_bits),
    .c0     (c0),
    .c1     (c1),
    .c2     (c2),
    .c3     (c3),
    .c4     (c4),
    .c5     (c5),
    .c6     (c6),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Booth digit = -2*Q[1] + Q[0] + Q[-1], mapped to {c2,c3,c4}.
  function automatic logic [8:0] exp_eval(input logic [2:0] q);
    int         d;
    logic [2:0] s;
    d = int'(q[1]) + int'(q[0]) - 2 * int'(q[2]);
    case (d)
      0:       s = 3'b000;
      1:       s = 3'b100;
      2:       s = 3'b110;
      -1:      s = 3'b101;
      -2:      s = 3'b111;
      default: s = 3'bxxx;
    endcase
    return {2'b00, s, 2'b00, 2'b10};
  endfunction

  // Expected vector in cycle c of a run (cycle 1 = INIT).
  function automatic logic [8:0] exp_cycle(input int c, input logic [2:0] q);
    if (c == 1)                     return E_INIT;
    if (c == 2 * N + 2)             return E_OUT;
    if (c >= 2 && c <= 2 * N + 1)   return (c % 2 == 0) ? exp_eval(q) : E_SHIFT;
    return E_IDLE;
  endfunction

  // Strobe exclusivity and c3/c4 gating observed every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("excl_c0_c2_c5_c6", {8'd0, $onehot0({c0, c2, c5, c6})}, 9'd1);
      chk("c3_c4_outside_eval", {8'd0, !((c3 | c4) && !c2)}, 9'd1);
    end
  end

  logic [2:0] sw_q [4];
  logic [8:0] sw_e [4];
  logic [2:0] rq;

  initial begin
    sw_q = '{3'b001, 3'b011, 3'b100, 3'b110};
    sw_e = '{9'b00_100_00_10, 9'b00_110_00_10, 9'b00_111_00_10, 9'b00_101_00_10};

    // ---- reset state
    reset  = 1'b1;
    start  = 1'b0;
    q_bits = 3'b000;
    tick();
    tick();
    chk("reset_state", outs, E_IDLE);
    reset = 1'b0;
    tick();
    chk("idle_after_reset", outs, E_IDLE);
    mon_en = 1'b1;

    // ---- full run, q_bits = 000
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run000_c1", outs, E_INIT);
    for (int c = 2; c <= 11; c++) begin
      tick();
      chk($sformatf("run000_c%0d", c), outs, exp_cycle(c, 3'b000));
    end

    // ---- recode sweep, q_bits unknown outside EVAL
    q_bits = 3'bxxx;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("sweep_init_xq", outs, E_INIT);
    for (int i = 0; i < 4; i++) begin
      q_bits = sw_q[i];
      tick();
      chk($sformatf("sweep_eval%0d", i), outs, sw_e[i]);
      q_bits = 3'bxxx;
      tick();
      chk($sformatf("sweep_shift%0d_xq", i), outs, E_SHIFT);
    end
    tick();
    chk("sweep_out_xq", outs, E_OUT);
    tick();
    chk("sweep_idle_xq", outs, E_IDLE);
    q_bits = 3'b000;

    // ---- start pulsed in cycle 4 is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_c1", outs, E_INIT);
    done_cnt = 0;
    for (int c = 2; c <= 12; c++) begin
      tick();
      start = (c == 4);
      chk($sformatf("ign_c%0d", c), outs, exp_cycle(c, 3'b000));
      done_cnt += int'(done);
    end
    start = 1'b0;
    chk("ign_done_count", 9'(done_cnt), 9'd1);

    // ---- back-to-back with start held high
    start    = 1'b1;
    done_cnt = 0;
    for (int c = 1; c <= 23; c++) begin
      tick();
      if (c == 21) start = 1'b0;
      if (c <= 11)      chk($sformatf("b2b_c%0d", c), outs, exp_cycle(c, 3'b000));
      else if (c <= 21) chk($sformatf("b2b_c%0d", c), outs, exp_cycle(c - 11, 3'b000));
      else              chk($sformatf("b2b_c%0d", c), outs, E_IDLE);
      done_cnt += int'(done);
    end
    chk("b2b_done_count", 9'(done_cnt), 9'd2);

    // ---- random q_bits runs (Mealy outputs checked after q changes)
    for (int r = 0; r < 2; r++) begin
      start = 1'b1;
      for (int c = 1; c <= 11; c++) begin
        tick();
        start  = 1'b0;
        rq     = 3'($urandom_range(0, 7));
        q_bits = rq;
        #1;
        chk($sformatf("rnd%0d_c%0d", r, c), outs, exp_cycle(c, rq));
      end
    end
    q_bits = 3'b000;

    // ---- reset in SHIFT of iteration 2 (cycle 7)
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 7; c++) tick();
    chk("abort_pre_c7", outs, E_SHIFT);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_async_zero", outs, E_IDLE);
    tick();
    chk("abort_held", outs, E_IDLE);
    reset    = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      done_cnt += int'(done);
    end
    chk("abort_idle", outs, E_IDLE);
    chk("abort_no_done", 9'(done_cnt), 9'd0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_booth4_ctrl
`default_nettype wire
